vc_dir_arbiter: RTL and testbench
=================================

VC_DIR_ARBITER -- requirements
Module: vc_dir_arbiter

Interface
REQ-001 SHALL have parameter NUM_VC, default 4, number of virtual channels (requesters).
REQ-002 SHALL have parameter NUM_DIR, default 12, number of output directions (shared resources).
REQ-003 SHALL have parameter DIR_W, default 4, width of one direction index; 2**DIR_W >= NUM_DIR.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  NUM_VC  per-VC request level.
REQ-007 SHALL have port req_dir  input  NUM_VC*DIR_W  per-VC requested direction; VC k uses bits [k*DIR_W +: DIR_W].
REQ-008 SHALL have port rel  input  NUM_VC  per-VC release pulse.
REQ-009 SHALL have port grant  output  NUM_VC  per-VC grant level, registered.
REQ-010 SHALL have port dir_busy  output  NUM_DIR  per-direction ownership flag, registered.
REQ-011 SHALL have port dir_err  output  NUM_VC  one-cycle pulse, out-of-range direction requested.
REQ-012 SHALL have port stall_cnt  output  16  count of cycles with blocked requesters (see Configuration).

Function
REQ-013 SHALL keep a per-VC FSM with states IDLE, WAIT and GRANTED, plus a DIR_W-bit captured direction.
REQ-014 IDLE: when req[k]=1 and req_dir<NUM_DIR, the FSM SHALL capture req_dir and enter WAIT on the next edge.
REQ-015 IDLE: when req[k]=1 and req_dir>=NUM_DIR, the FSM SHALL stay IDLE, and dir_err[k] SHALL pulse high for exactly one cycle per such cycle.
REQ-016 WAIT: when req[k]=0, the FSM SHALL return to IDLE without a grant (cancel); the captured direction is ignored once cancelled.
REQ-017 Each cycle, for each direction d with dir_busy[d]=0, the block SHALL select one WAIT VC whose captured dir==d, by round-robin.
REQ-018 Round-robin: each direction SHALL hold its own pointer; search starts at pointer; after a grant to VC k the pointer becomes (k+1) mod NUM_VC.
REQ-019 The selected VC SHALL enter GRANTED, with grant[k]=1 and dir_busy[d]=1 from the next edge (latency 1 cycle from the WAIT cycle).
REQ-020 At most one VC SHALL be GRANTED per direction; different directions SHALL grant concurrently in the same cycle.
REQ-021 GRANTED: rel[k]=1 SHALL clear grant[k] and dir_busy[d] on the next edge, after which the FSM returns to IDLE.
REQ-022 A released direction SHALL NOT be re-granted in the same cycle as rel; the earliest re-grant is visible 2 edges after rel.
REQ-023 GRANTED: req[k] SHALL be ignored; only rel ends ownership.
REQ-024 rel[k] in IDLE or WAIT SHALL be ignored.
REQ-025 A VC in IDLE with req=1 SHALL NOT be granted in that same cycle; it needs one cycle in WAIT first.

Reset
REQ-026 On reset=1 at a clock edge, all FSMs SHALL go to IDLE; grant, dir_busy, dir_err and stall_cnt SHALL be 0; all RR pointers SHALL be 0.
REQ-027 Reset mid-operation SHALL drop all ownership immediately with no release handshake; reset SHALL dominate req and rel in the same cycle.

Configuration
REQ-028 With macro VC_ARB_STATS_EN defined, stall_cnt SHALL increment by 1 in each cycle where at least one VC is in WAIT and not selected.
REQ-029 With VC_ARB_STATS_EN defined, stall_cnt SHALL saturate at 16'hFFFF and clear only on reset.
REQ-030 Without VC_ARB_STATS_EN, stall_cnt SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-031 Reset, then VC0 req dir=3 for 1 cycle -> WAIT; next edge grant=4'b0001, dir_busy[3]=1.
REQ-032 VC0..VC3 all req dir=5 simultaneously -> granted in order VC0, VC1, VC2, VC3, each after the prior rel; only one grant at a time.
REQ-033 VC1 dir=2 and VC2 dir=7 simultaneously -> both granted on the same edge; grant=4'b0110.
REQ-034 VC3 req dir=12 -> dir_err=4'b1000 one cycle, grant stays 0; VC2 in WAIT drops req -> returns to IDLE, never granted.
REQ-035 VC0 holds dir 0 while VC1 waits on dir 0, then reset asserted -> next edge grant=0, dir_busy=0; with VC_ARB_STATS_EN, stall_cnt nonzero before reset and 0 after.

Source files
------------

// File: rtl/vc_dir_arbiter.sv
// Per-VC request FSMs competing for shared output directions, with one round-robin pointer per direction.
// Optional stall statistics counter enabled by defining VC_ARB_STATS_EN.
module vc_dir_arbiter #(
   parameter int NUM_VC  = 4,
   parameter int NUM_DIR = 12,
   parameter int DIR_W   = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_VC-1:0]       req,
   input  logic [NUM_VC*DIR_W-1:0] req_dir,
   input  logic [NUM_VC-1:0]       rel,
   output logic [NUM_VC-1:0]       grant,
   output logic [NUM_DIR-1:0]      dir_busy,
   output logic [NUM_VC-1:0]       dir_err,
   output logic [15:0]             stall_cnt
);

   localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] WAIT    = 2'd1;
   localparam logic [1:0] GRANTED = 2'd2;

   logic [NUM_VC-1:0][1:0]       state;
   logic [NUM_VC-1:0][DIR_W-1:0] cap_dir;
   logic [NUM_DIR-1:0][VC_W-1:0] rr_ptr;

   logic [NUM_VC-1:0]            waiting;
   logic [NUM_VC-1:0]            sel;
   logic [NUM_DIR-1:0]           dir_win;
   logic [NUM_DIR-1:0][VC_W-1:0] win_vc;
   logic [NUM_DIR-1:0]           dir_rel;

   function automatic int rr_idx(input logic [VC_W-1:0] ptr, input int i);
      return (int'(ptr) + i) % NUM_VC;
   endfunction

   // A WAIT VC that drops req this cycle is cancelling and must not win.
   always_comb begin
      for (int k = 0; k < NUM_VC; k++)
         waiting[k] = (state[k] == WAIT) && req[k];
   end

   always_comb begin
      dir_win = '0;
      win_vc  = '0;
      sel     = '0;
      for (int d = 0; d < NUM_DIR; d++) begin
         if (!dir_busy[d]) begin
            for (int i = 0; i < NUM_VC; i++) begin
               if (!dir_win[d] && waiting[rr_idx(rr_ptr[d], i)] &&
                   cap_dir[rr_idx(rr_ptr[d], i)] == DIR_W'(d)) begin
                  dir_win[d] = 1'b1;
                  win_vc[d]  = VC_W'(rr_idx(rr_ptr[d], i));
                  sel[rr_idx(rr_ptr[d], i)] = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      dir_rel = '0;
      for (int k = 0; k < NUM_VC; k++)
         if (state[k] == GRANTED && rel[k])
            dir_rel[cap_dir[k]] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= '0;
         cap_dir <= '0;
         grant   <= '0;
         dir_err <= '0;
      end else begin
         for (int k = 0; k < NUM_VC; k++) begin
            dir_err[k] <= 1'b0;
            case (state[k])
               IDLE: begin
                  if (req[k]) begin
                     if (int'(req_dir[k*DIR_W +: DIR_W]) < NUM_DIR) begin
                        state[k]   <= WAIT;
                        cap_dir[k] <= req_dir[k*DIR_W +: DIR_W];
                     end else begin
                        dir_err[k] <= 1'b1;
                     end
                  end
               end
               WAIT: begin
                  if (!req[k]) begin
                     state[k] <= IDLE;
                  end else if (sel[k]) begin
                     state[k] <= GRANTED;
                     grant[k] <= 1'b1;
                  end
               end
               GRANTED: begin
                  if (rel[k]) begin
                     state[k] <= IDLE;
                     grant[k] <= 1'b0;
                  end
               end
               default: begin
                  state[k] <= IDLE;
                  grant[k] <= 1'b0;
               end
            endcase
         end
      end
   end

   // A direction is never granted and released in the same cycle: grant needs busy=0, release needs an owner.
   always_ff @(posedge clock) begin
      if (reset) begin
         dir_busy <= '0;
         rr_ptr   <= '0;
      end else begin
         for (int d = 0; d < NUM_DIR; d++) begin
            if (dir_win[d]) begin
               dir_busy[d] <= 1'b1;
               rr_ptr[d]   <= (win_vc[d] == VC_W'(NUM_VC - 1)) ? '0 : win_vc[d] + 1'b1;
            end else if (dir_rel[d]) begin
               dir_busy[d] <= 1'b0;
            end
         end
      end
   end

`ifdef VC_ARB_STATS_EN
   logic stall;

   always_comb begin
      stall = 1'b0;
      for (int k = 0; k < NUM_VC; k++)
         if (state[k] == WAIT && !sel[k])
            stall = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset)
         stall_cnt <= '0;
      else if (stall && stall_cnt != 16'hFFFF)
         stall_cnt <= stall_cnt + 16'd1;
   end
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vc_dir_arbiter.sv
// Directed bench for vc_dir_arbiter: grant latency, per-direction round-robin, concurrency, errors, cancel, reset.
module tb_vc_dir_arbiter;

   logic        clock;
   logic        reset;
   logic [3:0]  req;
   logic [15:0] req_dir;
   logic [3:0]  rel;
   logic [3:0]  grant;
   logic [11:0] dir_busy;
   logic [3:0]  dir_err;
   logic [15:0] stall_cnt;

   int total  = 0;
   int passed = 0;

   vc_dir_arbiter #(.NUM_VC(4), .NUM_DIR(12), .DIR_W(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .req_dir   (req_dir),
      .rel       (rel),
      .grant     (grant),
      .dir_busy  (dir_busy),
      .dir_err   (dir_err),
      .stall_cnt (stall_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Inputs change 1ns after an edge; outputs are checked 1ns after the next edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_dir(input int k, input logic [3:0] v);
      req_dir[k*4 +: 4] = v;
   endtask

   task automatic test_reset();
      reset = 1'b1; req = '0; req_dir = '0; rel = '0;
      step(); step();
      total++; if (grant !== 4'b0) $display("FAIL reset_grant: got %b want %b", grant, 4'b0); else passed++;
      total++; if (dir_busy !== 12'b0) $display("FAIL reset_busy: got %b want %b", dir_busy, 12'b0); else passed++;
      total++; if (dir_err !== 4'b0) $display("FAIL reset_err: got %b want %b", dir_err, 4'b0); else passed++;
      total++; if (stall_cnt !== 16'd0) $display("FAIL reset_stall: got %0d want 0", stall_cnt); else passed++;
      reset = 1'b0;
   endtask

   task automatic test_single();
      req = 4'b0001; set_dir(0, 4'd3);
      step();
      total++; if (grant !== 4'b0000) $display("FAIL single_wait_grant: got %b want %b", grant, 4'b0000); else passed++;
      step();
      total++; if (grant !== 4'b0001) $display("FAIL single_grant: got %b want %b", grant, 4'b0001); else passed++;
      total++; if (dir_busy !== 12'h008) $display("FAIL single_busy: got %b want %b", dir_busy, 12'h008); else passed++;
      req = 4'b0000; rel = 4'b0001;
      step(); rel = 4'b0000;
      total++; if (grant !== 4'b0000) $display("FAIL single_rel_grant: got %b want %b", grant, 4'b0000); else passed++;
      total++; if (dir_busy !== 12'h000) $display("FAIL single_rel_busy: got %b want %b", dir_busy, 12'h000); else passed++;
   endtask

   task automatic test_rr_same_dir();
      for (int k = 0; k < 4; k++) set_dir(k, 4'd5);
      req = 4'b1111;
      step();
      total++; if (grant !== 4'b0000) $display("FAIL rr_wait: got %b want %b", grant, 4'b0000); else passed++;
      step();
      total++; if (grant !== 4'b0001) $display("FAIL rr_vc0: got %b want %b", grant, 4'b0001); else passed++;
      total++; if (dir_busy !== 12'h020) $display("FAIL rr_busy: got %b want %b", dir_busy, 12'h020); else passed++;
      rel = 4'b0001; req = 4'b1110;
      step(); rel = 4'b0000;
      total++; if (grant !== 4'b0000) $display("FAIL rr_gap0: got %b want %b", grant, 4'b0000); else passed++;
      step();
      total++; if (grant !== 4'b0010) $display("FAIL rr_vc1: got %b want %b", grant, 4'b0010); else passed++;
      rel = 4'b0010; req = 4'b1100;
      step(); rel = 4'b0000;
      total++; if (grant !== 4'b0000) $display("FAIL rr_gap1: got %b want %b", grant, 4'b0000); else passed++;
      step();
      total++; if (grant !== 4'b0100) $display("FAIL rr_vc2: got %b want %b", grant, 4'b0100); else passed++;
      rel = 4'b0100; req = 4'b1000;
      step(); rel = 4'b0000;
      step();
      total++; if (grant !== 4'b1000) $display("FAIL rr_vc3: got %b want %b", grant, 4'b1000); else passed++;
      rel = 4'b1000; req = 4'b0000;
      step(); rel = 4'b0000;
      total++; if (dir_busy !== 12'h000) $display("FAIL rr_end_busy: got %b want %b", dir_busy, 12'h000); else passed++;
   endtask

   task automatic test_concurrent();
      set_dir(1, 4'd2); set_dir(2, 4'd7);
      req = 4'b0110;
      step(); step();
      total++; if (grant !== 4'b0110) $display("FAIL conc_grant: got %b want %b", grant, 4'b0110); else passed++;
      total++; if (dir_busy !== 12'h084) $display("FAIL conc_busy: got %b want %b", dir_busy, 12'h084); else passed++;
      rel = 4'b0110; req = 4'b0000;
      step(); rel = 4'b0000;
      total++; if (grant !== 4'b0000) $display("FAIL conc_rel: got %b want %b", grant, 4'b0000); else passed++;
   endtask

   // Direction 2 pointer sits at 2 after VC1 won it above, so VC3 beats VC0.
   task automatic test_rr_pointer();
      set_dir(0, 4'd2); set_dir(1, 4'd2); set_dir(3, 4'd2);
      req = 4'b1011;
      step(); step();
      total++; if (grant !== 4'b1000) $display("FAIL ptr_vc3: got %b want %b", grant, 4'b1000); else passed++;
      rel = 4'b1000; req = 4'b0011;
      step(); rel = 4'b0000;
      step();
      total++; if (grant !== 4'b0001) $display("FAIL ptr_wrap_vc0: got %b want %b", grant, 4'b0001); else passed++;
      rel = 4'b0001; req = 4'b0010;
      step(); rel = 4'b0000;
      step();
      total++; if (grant !== 4'b0010) $display("FAIL ptr_vc1: got %b want %b", grant, 4'b0010); else passed++;
      rel = 4'b0010; req = 4'b0000;
      step(); rel = 4'b0000;
   endtask

   task automatic test_err_cancel();
      set_dir(3, 4'd12); set_dir(2, 4'd9);
      req = 4'b1100;
      step();
      total++; if (dir_err !== 4'b1000) $display("FAIL err_pulse: got %b want %b", dir_err, 4'b1000); else passed++;
      total++; if (grant !== 4'b0000) $display("FAIL err_grant: got %b want %b", grant, 4'b0000); else passed++;
      req = 4'b0000;
      step();
      total++; if (dir_err !== 4'b0000) $display("FAIL err_clear: got %b want %b", dir_err, 4'b0000); else passed++;
      total++; if (grant !== 4'b0000) $display("FAIL cancel_grant: got %b want %b", grant, 4'b0000); else passed++;
      step();
      total++; if (dir_busy !== 12'h000) $display("FAIL cancel_busy: got %b want %b", dir_busy, 12'h000); else passed++;
   endtask

   task automatic test_rel_ignored();
      set_dir(0, 4'd1);
      req = 4'b0001; rel = 4'b0001;
      step(); step();
      total++; if (grant !== 4'b0001) $display("FAIL relign_grant: got %b want %b", grant, 4'b0001); else passed++;
      req = 4'b0000;
      step(); rel = 4'b0000;
      total++; if (grant !== 4'b0000) $display("FAIL relign_release: got %b want %b", grant, 4'b0000); else passed++;
   endtask

   task automatic test_reset_mid();
      set_dir(0, 4'd0); set_dir(1, 4'd0);
      req = 4'b0011;
      step(); step();
      total++; if (grant !== 4'b0001) $display("FAIL rmid_grant: got %b want %b", grant, 4'b0001); else passed++;
      req = 4'b0010;
      step();
      total++; if (grant !== 4'b0001) $display("FAIL rmid_req_ignored: got %b want %b", grant, 4'b0001); else passed++;
      total++; if (dir_busy !== 12'h001) $display("FAIL rmid_busy: got %b want %b", dir_busy, 12'h001); else passed++;
`ifdef VC_ARB_STATS_EN
      total++; if (stall_cnt === 16'd0) $display("FAIL rmid_stall_pre: got %0d want nonzero", stall_cnt); else passed++;
`else
      total++; if (stall_cnt !== 16'd0) $display("FAIL rmid_stall_pre: got %0d want 0", stall_cnt); else passed++;
`endif
      reset = 1'b1; rel = 4'b0001;
      step();
      reset = 1'b0; rel = 4'b0000;
      total++; if (grant !== 4'b0000) $display("FAIL rmid_reset_grant: got %b want %b", grant, 4'b0000); else passed++;
      total++; if (dir_busy !== 12'h000) $display("FAIL rmid_reset_busy: got %b want %b", dir_busy, 12'h000); else passed++;
      total++; if (stall_cnt !== 16'd0) $display("FAIL rmid_stall_post: got %0d want 0", stall_cnt); else passed++;
      step();
      total++; if (grant !== 4'b0000) $display("FAIL rmid_rewait: got %b want %b", grant, 4'b0000); else passed++;
      step();
      total++; if (grant !== 4'b0010) $display("FAIL rmid_regrant: got %b want %b", grant, 4'b0010); else passed++;
      rel = 4'b0010; req = 4'b0000;
      step(); rel = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_single();
      test_rr_same_dir();
      test_concurrent();
      test_rr_pointer();
      test_err_cancel();
      test_rel_ignored();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
